in_port_sw: RTL and testbench
=============================

Name: in_port_sw

Overview:
- Input-side counterpart of the two-digit seven-segment output port.
- Samples two 4-bit switch groups: tens digit and units digit.
- Synchronises and debounces them, then clamps each digit to 0..9.
- Presents the binary value tens*10+units, zero-extended to 32 bits, on the CPU I/O read bus.
- Raises a data_valid flag when the value changes; the flag is cleared by a CPU read strobe.

Parameters:
- DEBOUNCE_CYCLES, 50000, number of consecutive stable clock cycles required before a switch change is accepted. Minimum 1.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), width of the debounce counter. Derived; never overridden.

Ports:
- clock  in  1  system clock; everything is rising-edge.
- resetn  in  1  asynchronous, active-low reset.
- sw_ten  in  4  raw tens-digit switches, asynchronous to clock.
- sw_mod  in  4  raw units-digit switches, asynchronous to clock.
- rd_en  in  1  CPU read strobe, one cycle per read.
- data_out  out  32  current value, 0..99, zero-extended.
- data_valid  out  1  an unread new value is present.
- err_digit  out  1  a stable digit currently exceeds 9.

Behaviour:
- Reset (resetn low, asynchronous): all of the following clear to 0.
  - Synchroniser flops, candidate, counter, stable register.
  - data_out, data_valid, err_digit.
  - Reset mid-debounce discards the pending change.
- Synchroniser: a 2-flop chain on the 8-bit vector {sw_ten, sw_mod}. Output is raw_s.
- Debounce, operating on the whole 8-bit vector:
  - raw_s != candidate: candidate <= raw_s, cnt <= 0.
  - Otherwise, if cnt < DEBOUNCE_CYCLES-1: cnt increments.
  - Otherwise, if candidate != stable: stable <= candidate.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles leaves stable unchanged.
  - The counter saturates and does not wrap.
- Conversion, combinational from stable:
  - Each digit is clamped: d>9 becomes 9.
  - value = ten_c*10 + mod_c, which lies in 0..99. Compute in 7 bits, then zero-extend.
- Output register:
  - data_out <= value every cycle.
  - err_digit <= (stable ten >9) | (stable mod >9).
- Total latency from an input edge to data_out: 2 sync + DEBOUNCE_CYCLES + 2 cycles. The bench checks this exactly.
- data_valid:
  - Set on the cycle data_out takes a value different from its previous value.
  - Cleared on the cycle after rd_en=1.
  - Set and rd_en in the same cycle: set wins, so new data is not lost.
  - rd_en while data_valid=0: no effect.
  - Reading never alters data_out.
- Power-up with all switches at 0 produces no data_valid, because the value equals the reset value.
- Power-up with non-zero switches sets data_valid after the full latency.
- A clamped change does not set data_valid if the clamped value is unchanged; for example, ten 10 -> 11 still yields ten_c=9.
  - err_digit still tracks the raw stable digits in that case.

Optional Feature:
- Macro: IN_PORT_IRQ_EN.
- Defined: adds output irq (1 bit, reset 0).
  - irq is a one-cycle pulse on the cycle after data_valid rises 0->1.
  - No pulse is generated while data_valid is already 1.
- Undefined: the irq port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package in_port_pkg holds:
  - DATA_W=32, DIGIT_W=4, DIGIT_MAX=4'd9, VALUE_W=7.
  - Function clamp_digit.
- Sub-module in_port_debounce, parameterised by WIDTH and DEBOUNCE_CYCLES:
  - Contains the 2-flop synchroniser and the debounce counter.
  - Outputs stable[WIDTH-1:0].
- The top level holds conversion, the output register, the valid/read logic and the optional irq.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset with switches 0, then run 20 cycles -> data_out=0, data_valid=0, err_digit=0 throughout.
- sw_ten=4, sw_mod=2 held -> data_out=42 exactly 8 cycles after the change and data_valid=1. Pulse rd_en -> data_valid=0 the next cycle; data_out stays 42.
- sw_mod toggles 2->7->2, each level held 2 cycles, then steady at 2 -> data_out remains 42 and data_valid stays 0.
- sw_ten=12, sw_mod=3 -> data_out=93, err_digit=1. Then sw_ten=15 -> data_out stays 93, err_digit=1, no new data_valid.
- With data_valid=1, assert rd_en on the same cycle the value changes 42->57 -> data_valid remains 1 and data_out=57.
- Assert resetn low mid-debounce after a change to 9/9 -> outputs 0 immediately. Release -> data_out=99 after full latency and data_valid=1; with IN_PORT_IRQ_EN, irq pulses exactly once.

Source files
------------

// File: rtl/in_port_pkg.sv
// -----------------------------------------------------------------------------
// in_port_pkg
// Shared constants and helpers for the two-digit switch input port.
// The digit widths, the clamp limit and the value width live here so the
// debounce block and the top level agree on them.
// -----------------------------------------------------------------------------
package in_port_pkg;

    // CPU read-bus width
    localparam int DATA_W  = 32;
    // Width of one BCD-style switch digit
    localparam int DIGIT_W = 4;
    // Largest legal decimal digit
    localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;
    // Width of tens*10+units (0..99 fits in 7 bits)
    localparam int VALUE_W = 7;
    // Weight of the tens digit, already at value width
    localparam logic [VALUE_W-1:0] TEN_WEIGHT = 7'd10;

    // Limit a raw switch digit to the decimal range 0..9.
    function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] d);
        logic [DIGIT_W-1:0] r;
        if (d > DIGIT_MAX) begin
            r = DIGIT_MAX;
        end else begin
            r = d;
        end
        return r;
    endfunction

    // Flag a raw switch digit that lies outside the decimal range.
    function automatic logic digit_over(input logic [DIGIT_W-1:0] d);
        return (d > DIGIT_MAX);
    endfunction

    // Combine two clamped digits into tens*10+units at value width.
    function automatic logic [VALUE_W-1:0] digits_to_value(
        input logic [DIGIT_W-1:0] ten_c,
        input logic [DIGIT_W-1:0] mod_c
    );
        logic [VALUE_W-1:0] ten_w;
        logic [VALUE_W-1:0] mod_w;
        ten_w = {3'b000, ten_c};
        mod_w = {3'b000, mod_c};
        return (ten_w * TEN_WEIGHT) + mod_w;
    endfunction

endpackage : in_port_pkg

// File: rtl/in_port_debounce.sv
// -----------------------------------------------------------------------------
// in_port_debounce
// Two-flop synchroniser followed by a whole-vector debouncer. A new input
// pattern must stay unchanged for DEBOUNCE_CYCLES consecutive cycles before
// it is copied into the stable register. Any change of any bit restarts the
// count, so a glitch shorter than the window never reaches the output.
// -----------------------------------------------------------------------------
module in_port_debounce
    import in_port_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 50000,
    localparam int CNT_W          = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] stable
);

    // Terminal count: the candidate has been seen DEBOUNCE_CYCLES times
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] cand_q;
    logic [WIDTH-1:0] cand_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [WIDTH-1:0] stable_q;
    logic [WIDTH-1:0] stable_d;
    logic [WIDTH-1:0] raw_s;

    assign raw_s = sync2_q;

    // Synchroniser chain: brings the asynchronous switches into the clock domain
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
        end
    end

    // Debounce decision: restart on change, count while steady, then commit
    always_comb begin
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (raw_s != cand_q) begin
            cand_d = raw_s;
            cnt_d  = '0;
        end else if (cnt_q < CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
        end else if (cand_q != stable_q) begin
            // counter is saturated here; it only restarts on a new change
            stable_d = cand_q;
        end else begin
            stable_d = stable_q;
        end
    end

    // Debounce state registers
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cand_q   <= '0;
            cnt_q    <= '0;
            stable_q <= '0;
        end else begin
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign stable = stable_q;

endmodule : in_port_debounce

// File: rtl/in_port_sw.sv
// -----------------------------------------------------------------------------
// in_port_sw
// Two-digit switch input port for the CPU I/O bus. The tens and units switch
// groups are synchronised and debounced together, each digit is clamped to
// 0..9, and tens*10+units is presented zero-extended on data_out.
// data_valid flags an unread new value and is cleared by the rd_en strobe;
// a new value arriving together with a read keeps the flag set.
//
// Build option: define IN_PORT_IRQ_EN to add the irq output, a one-cycle
// pulse on the cycle after data_valid rises.
// -----------------------------------------------------------------------------
module in_port_sw
    import in_port_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic [DIGIT_W-1:0] sw_ten,
    input  logic [DIGIT_W-1:0] sw_mod,
    input  logic              rd_en,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              err_digit
`ifdef IN_PORT_IRQ_EN
    ,
    output logic              irq
`endif
);

    localparam int SW_W = 2 * DIGIT_W;

    logic [SW_W-1:0]    stable_s;
    logic [DIGIT_W-1:0] ten_s;
    logic [DIGIT_W-1:0] mod_s;
    logic [DIGIT_W-1:0] ten_c_s;
    logic [DIGIT_W-1:0] mod_c_s;
    logic [VALUE_W-1:0] value_s;
    logic               new_val_s;

    logic [DATA_W-1:0]  data_out_q;
    logic [DATA_W-1:0]  data_out_d;
    logic               data_valid_q;
    logic               data_valid_d;
    logic               err_digit_q;
    logic               err_digit_d;

    // Tens digit occupies the upper nibble of the debounced vector
    in_port_debounce #(
        .WIDTH           (SW_W),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clock  (clock),
        .resetn (resetn),
        .din    ({sw_ten, sw_mod}),
        .stable (stable_s)
    );

    assign ten_s = stable_s[SW_W-1:DIGIT_W];
    assign mod_s = stable_s[DIGIT_W-1:0];

    // Conversion of the stable digits into the binary value and next outputs
    always_comb begin
        ten_c_s      = clamp_digit(ten_s);
        mod_c_s      = clamp_digit(mod_s);
        value_s      = digits_to_value(ten_c_s, mod_c_s);
        data_out_d   = {{(DATA_W - VALUE_W){1'b0}}, value_s};
        err_digit_d  = digit_over(ten_s) | digit_over(mod_s);
        // compare on the clamped value so out-of-range wiggles stay silent
        new_val_s    = (data_out_d != data_out_q);
        data_valid_d = data_valid_q;
        if (new_val_s) begin
            // a fresh value wins over a simultaneous read
            data_valid_d = 1'b1;
        end else if (rd_en) begin
            data_valid_d = 1'b0;
        end else begin
            data_valid_d = data_valid_q;
        end
    end

    // Output registers seen by the CPU bus
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            err_digit_q  <= 1'b0;
        end else begin
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            err_digit_q  <= err_digit_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign err_digit  = err_digit_q;

`ifdef IN_PORT_IRQ_EN
    logic dv_prev_q;
    logic dv_prev_d;
    logic irq_q;
    logic irq_d;

    // Rising-edge detect on data_valid, one cycle behind the flag itself
    always_comb begin
        dv_prev_d = data_valid_q;
        irq_d     = data_valid_q & ~dv_prev_q;
    end

    // Interrupt pulse registers
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            dv_prev_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            dv_prev_q <= dv_prev_d;
            irq_q     <= irq_d;
        end
    end

    assign irq = irq_q;
`endif

endmodule : in_port_sw

// File: tb/tb_in_port_sw.sv
// -----------------------------------------------------------------------------
// tb_in_port_sw
// Directed bench for in_port_sw with DEBOUNCE_CYCLES=4, giving an input-edge
// to data_out latency of 2+4+2 = 8 clocks. Inputs are driven and outputs are
// sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_in_port_sw;

    logic        clock;
    logic        resetn;
    logic [3:0]  sw_ten;
    logic [3:0]  sw_mod;
    logic        rd_en;
    logic [31:0] data_out;
    logic        data_valid;
    logic        err_digit;
`ifdef IN_PORT_IRQ_EN
    logic        irq;
`endif

    int checks = 0;
    int errors = 0;

    in_port_sw #(
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clock      (clock),
        .resetn     (resetn),
        .sw_ten     (sw_ten),
        .sw_mod     (sw_mod),
        .rd_en      (rd_en),
        .data_out   (data_out),
        .data_valid (data_valid),
        .err_digit  (err_digit)
`ifdef IN_PORT_IRQ_EN
        ,
        .irq        (irq)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [31:0] dout,
                              input logic dv, input logic err);
        check({tag, "_data_out"}, data_out, dout);
        check({tag, "_data_valid"}, {31'd0, data_valid}, {31'd0, dv});
        check({tag, "_err_digit"}, {31'd0, err_digit}, {31'd0, err});
    endtask

    initial begin
        resetn = 1'b0;
        sw_ten = 4'd0;
        sw_mod = 4'd0;
        rd_en  = 1'b0;

        // Reset state
        #2;
        check_outs("reset", 32'd0, 1'b0, 1'b0);
`ifdef IN_PORT_IRQ_EN
        check("reset_irq", {31'd0, irq}, 32'd0);
`endif
        tick(2);
        resetn = 1'b1;

        // Power-up with switches at 0: nothing ever changes
        for (int i = 0; i < 20; i++) begin
            tick(1);
            check_outs("idle", 32'd0, 1'b0, 1'b0);
        end

        // 4/2 -> 42 exactly 8 cycles after the change
        sw_ten = 4'd4;
        sw_mod = 4'd2;
        tick(7);
        check_outs("lat42_before", 32'd0, 1'b0, 1'b0);
        tick(1);
        check_outs("lat42_at", 32'd42, 1'b1, 1'b0);

        // Read clears data_valid next cycle, data_out untouched
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
        check_outs("read42", 32'd42, 1'b0, 1'b0);

        // Read while nothing is pending has no effect
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
        check_outs("idle_read", 32'd42, 1'b0, 1'b0);

        // Short glitches on the units digit are rejected
        sw_mod = 4'd7;
        tick(2);
        sw_mod = 4'd2;
        tick(2);
        sw_mod = 4'd7;
        tick(2);
        sw_mod = 4'd2;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            check_outs("glitch", 32'd42, 1'b0, 1'b0);
        end

        // Out-of-range tens digit clamps to 9
        sw_ten = 4'd12;
        sw_mod = 4'd3;
        tick(7);
        check_outs("clamp_before", 32'd42, 1'b0, 1'b0);
        tick(1);
        check_outs("clamp_at", 32'd93, 1'b1, 1'b1);
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
        check_outs("clamp_read", 32'd93, 1'b0, 1'b1);

        // 12 -> 15 keeps the clamped value: no new data_valid
        sw_ten = 4'd15;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            check_outs("clamp_same", 32'd93, 1'b0, 1'b1);
        end

        // Back to 42, leave it unread
        sw_ten = 4'd4;
        sw_mod = 4'd2;
        tick(8);
        check_outs("back42", 32'd42, 1'b1, 1'b0);

        // 42 -> 57 with a read landing on the update edge: set wins
        sw_ten = 4'd5;
        sw_mod = 4'd7;
        tick(7);
        check_outs("set_rd_before", 32'd42, 1'b1, 1'b0);
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
        check_outs("set_rd_at", 32'd57, 1'b1, 1'b0);
        tick(1);
        check_outs("set_rd_hold", 32'd57, 1'b1, 1'b0);
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
        check_outs("set_rd_clear", 32'd57, 1'b0, 1'b0);

        // Reset in the middle of a debounce towards 9/9
        sw_ten = 4'd9;
        sw_mod = 4'd9;
        tick(3);
        resetn = 1'b0;
        #1;
        check_outs("mid_reset", 32'd0, 1'b0, 1'b0);
`ifdef IN_PORT_IRQ_EN
        check("mid_reset_irq", {31'd0, irq}, 32'd0);
`endif
        tick(1);
        check_outs("held_reset", 32'd0, 1'b0, 1'b0);
        resetn = 1'b1;

        // Full latency again after release
        tick(7);
        check_outs("rel_before", 32'd0, 1'b0, 1'b0);
        tick(1);
        check_outs("rel_at", 32'd99, 1'b1, 1'b0);
`ifdef IN_PORT_IRQ_EN
        check("irq_with_dv", {31'd0, irq}, 32'd0);
        tick(1);
        check("irq_pulse", {31'd0, irq}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            tick(1);
            check("irq_after", {31'd0, irq}, 32'd0);
        end
`else
        tick(1);
`endif
        check_outs("rel_hold", 32'd99, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_in_port_sw
